// File: rtl/common_param.sv
// Shared MIPS-style constants: opcode/funct fields plus HI/LO multiply-divide encodings.
package common_param;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1a;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

   localparam int unsigned MULDIV_WIDTH_MIN = 8;
   localparam int unsigned MULDIV_WIDTH_MAX = 64;

   typedef enum logic [2:0] {
      OpMult  = 3'd0,
      OpMultu = 3'd1,
      OpDiv   = 3'd2,
      OpDivu  = 3'd3,
      OpMthi  = 3'd4,
      OpMtlo  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPrep = 2'd1,
      StIter = 2'd2,
      StFix  = 2'd3
   } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide, one bit per cycle.
module muldiv_core
   import common_param::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] quo,
   output logic             last
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   always_comb begin
      sum     = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
      shifted = {acc_q, q_q[WIDTH-1]};
      diff    = shifted - {1'b0, m_q};
      ge      = shifted >= {1'b0, m_q};
      if (is_div) begin
         acc_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         q_d   = {q_q[WIDTH-2:0], ge};
      end else begin
         // {acc,q} holds the partial product; shift right after the conditional add.
         acc_d = sum[WIDTH:1];
         q_d   = {sum[0], q_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         q_q   <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         acc_q <= '0;
         q_q   <= is_div ? mag_a : mag_b;
         m_q   <= is_div ? mag_b : mag_a;
         cnt_q <= CW'(WIDTH);
      end else if (step) begin
         acc_q <= acc_d;
         q_q   <= q_d;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign acc  = acc_q;
   assign quo  = q_q;
   assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: control FSM, sign handling and architectural HI/LO registers.
module muldiv_unit
   import common_param::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] Rdata1,
   input  logic [WIDTH-1:0] Rdata2,
   input  logic             Abort,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   if (WIDTH < MULDIV_WIDTH_MIN || WIDTH > MULDIV_WIDTH_MAX || (WIDTH % 2) != 0) begin : g_bad_width
      $error("muldiv_unit: illegal WIDTH %0d", WIDTH);
   end

   md_state_t        state;
   md_op_t           op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             neg_q, rem_neg_q;

   logic               signed_op, is_div, a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   core_acc, core_quo;
   logic               core_last, core_load, core_step;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      signed_op = (op_q == OpMult) || (op_q == OpDiv);
      is_div    = (op_q == OpDiv) || (op_q == OpDivu);
      a_neg     = signed_op & a_q[WIDTH-1];
      b_neg     = signed_op & b_q[WIDTH-1];
      mag_a     = a_neg ? -a_q : a_q;
      mag_b     = b_neg ? -b_q : b_q;
      core_load = (state == StPrep) && !Abort;
      core_step = (state == StIter) && !Abort;
      prod      = {core_acc, core_quo};
      prod_fix  = neg_q ? -prod : prod;
      quot_fix  = neg_q ? -core_quo : core_quo;
      rem_fix   = rem_neg_q ? -core_acc : core_acc;
   end

   muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (CLK),
      .rst    (RST),
      .load   (core_load),
      .step   (core_step),
      .is_div (is_div),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .acc    (core_acc),
      .quo    (core_quo),
      .last   (core_last)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= StIdle;
         op_q      <= OpMult;
         a_q       <= '0;
         b_q       <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivZero   <= 1'b0;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         Done <= 1'b0;
         unique case (state)
            StIdle: begin
               // Busy lingers through the Done cycle, so requests are gated by it too.
               Busy <= 1'b0;
               if (Start && !Abort && !Busy) begin
                  case (Op)
                     OpMult, OpMultu, OpDiv, OpDivu: begin
                        op_q  <= md_op_t'(Op);
                        a_q   <= Rdata1;
                        b_q   <= Rdata2;
                        Busy  <= 1'b1;
                        state <= StPrep;
                     end
                     OpMthi:  Hi <= Rdata1;
                     OpMtlo:  Lo <= Rdata1;
                     default: ;
                  endcase
               end
            end
            StPrep: begin
               if (Abort) begin
                  Busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  neg_q     <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  state     <= StIter;
               end
            end
            StIter: begin
               if (Abort) begin
                  Busy  <= 1'b0;
                  state <= StIdle;
               end else if (core_last) begin
                  state <= StFix;
               end
            end
            StFix: begin
               state <= StIdle;
               if (Abort) begin
                  Busy <= 1'b0;
               end else begin
                  Done <= 1'b1;
                  if (!is_div) begin
                     Hi <= prod_fix[2*WIDTH-1:WIDTH];
                     Lo <= prod_fix[WIDTH-1:0];
                  end else if (b_q == '0) begin
                     Hi      <= a_q;
                     Lo      <= '1;
                     DivZero <= 1'b1;
                  end else begin
                     Hi      <= rem_fix;
                     Lo      <= quot_fix;
                     DivZero <= 1'b0;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=16.
module tb_muldiv_unit;
   import common_param::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rdata1 = '0, rdata2 = '0;
   logic        abort = 1'b0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   logic        start16 = 1'b0;
   logic [2:0]  op16 = 3'd0;
   logic [15:0] rdata1_16 = '0, rdata2_16 = '0;
   logic        abort16 = 1'b0;
   logic        busy16, done16, div_zero16;
   logic [15:0] hi16, lo16;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .CLK(clk), .RST(rst), .Start(start), .Op(op), .Rdata1(rdata1), .Rdata2(rdata2),
      .Abort(abort), .Busy(busy), .Done(done), .DivZero(div_zero), .Hi(hi), .Lo(lo)
   );

   muldiv_unit #(.WIDTH(16)) dut16 (
      .CLK(clk), .RST(rst), .Start(start16), .Op(op16), .Rdata1(rdata1_16),
      .Rdata2(rdata2_16), .Abort(abort16), .Busy(busy16), .Done(done16),
      .DivZero(div_zero16), .Hi(hi16), .Lo(lo16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept at edge N, expect the result with Done at N+34 and Busy low at N+35.
   task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input bit poke);
      int early;
      @(negedge clk);
      start = 1'b1; op = o; rdata1 = a; rdata2 = b;
      @(posedge clk); #1;
      start = 1'b0; rdata1 = 32'hdead_beef; rdata2 = 32'h0bad_f00d;
      check({tag, " busy"}, 64'(busy), 64'd1);
      early = 0;
      for (int k = 1; k <= 33; k++) begin
         @(posedge clk); #1;
         if (done) early++;
         if (poke && k == 10) begin
            start = 1'b1; op = OpMult; rdata1 = 32'h1111_1111; rdata2 = 32'h22;
         end else begin
            start = 1'b0;
         end
      end
      @(posedge clk); #1;
      check({tag, " early done"}, 64'(early), 64'd0);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check({tag, " divzero"}, 64'(div_zero), 64'(exp_dz));
      @(posedge clk); #1;
      check({tag, " done pulse"}, 64'(done), 64'd0);
      check({tag, " busy low"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int dcount;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst divzero", 64'(div_zero), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      @(negedge clk); rst = 1'b0;

      run32("mult", OpMult, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
      run32("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 0);
      run32("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run32("div min/-1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);

      // Move-to operations take effect at the accepting edge without going busy.
      @(negedge clk); start = 1'b1; op = OpMthi; rdata1 = 32'h1234;
      @(posedge clk); #1; start = 1'b0;
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi busy", 64'(busy), 64'd0);
      check("mthi done", 64'(done), 64'd0);
      @(negedge clk); start = 1'b1; op = OpMtlo; rdata1 = 32'h5678;
      @(posedge clk); #1; start = 1'b0;
      check("mtlo lo", 64'(lo), 64'h5678);
      check("mtlo hi kept", 64'(hi), 64'h1234);
      @(negedge clk); start = 1'b1; op = 3'd7; rdata1 = 32'hAAAA_AAAA;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      check("undef busy", 64'(busy), 64'd0);
      check("undef hilo", {hi, lo}, {32'h1234, 32'h5678});
      @(negedge clk); start = 1'b1; abort = 1'b1; op = OpMthi; rdata1 = 32'h9999;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
      check("abort+mthi hi", 64'(hi), 64'h1234);
      check("abort+mthi busy", 64'(busy), 64'd0);

      run32("divu 5/0", OpDivu, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1, 0);
      run32("div -8/0", OpDiv, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 0);
      run32("divu 9/3", OpDivu, 32'h9, 32'h3, 32'h0, 32'h3, 1'b0, 0);
      run32("mult poke", OpMult, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1);

      // Abort in ITER: back to IDLE next edge, HI/LO keep the previous result.
      @(negedge clk); start = 1'b1; op = OpMultu; rdata1 = 32'h1234_5678; rdata2 = 32'h10;
      @(posedge clk); #1; start = 1'b0;
      dcount = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) dcount++;
         if (k == 10) abort = 1'b1;
         if (k == 11) begin
            check("abort busy", 64'(busy), 64'd0);
            abort = 1'b0;
         end
      end
      check("abort done", 64'(dcount), 64'd0);
      check("abort hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

      run32("divu 5/0 again", OpDivu, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1, 0);
      @(negedge clk); start = 1'b1; op = OpMultu; rdata1 = 32'h3; rdata2 = 32'h4;
      @(posedge clk); #1; start = 1'b0;
      repeat (8) @(posedge clk);
      #1; rst = 1'b1;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      check("midrst divzero", 64'(div_zero), 64'd0);
      check("midrst hilo", {hi, lo}, 64'd0);
      @(posedge clk); #2; rst = 1'b0;
      run32("post-rst divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

      // WIDTH=16: result at N+18.
      @(negedge clk); start16 = 1'b1; op16 = OpMultu; rdata1_16 = 16'hFFFF; rdata2_16 = 16'hFFFF;
      @(posedge clk); #1; start16 = 1'b0; rdata1_16 = 16'h0; rdata2_16 = 16'h0;
      dcount = 0;
      repeat (17) begin
         @(posedge clk); #1;
         if (done16) dcount++;
      end
      @(posedge clk); #1;
      check("w16 early done", 64'(dcount), 64'd0);
      check("w16 done", 64'(done16), 64'd1);
      check("w16 hi", 64'(hi16), 64'hFFFE);
      check("w16 lo", 64'(lo16), 64'h0001);
      @(posedge clk); #1;
      check("w16 busy low", 64'(busy16), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
